// File: rtl/shift_reg_univ.sv
// Universal shift register: hold / shift left / shift right / parallel load, with saturating shift counter.
// Latency: one clk from enabled edge to pout; serial taps are combinational. No backpressure (enb gates all state).
// Optional rotate feature (port rot) enabled by defining SHIFT_REG_UNIV_ROTATE_EN.
module shift_reg_univ #(
    parameter  int DW  = 8,
    parameter  int SW  = 1,
    localparam int NSH = DW / SW,
    localparam int CW  = $clog2(NSH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enb,
    input  logic [1:0]    mode,
    input  logic [SW-1:0] sin_l,
    input  logic [SW-1:0] sin_r,
    input  logic [DW-1:0] pin,
`ifdef SHIFT_REG_UNIV_ROTATE_EN
    input  logic          rot,
`endif
    output logic [DW-1:0] pout,
    output logic [SW-1:0] sout_l,
    output logic [SW-1:0] sout_r,
    output logic [CW-1:0] cnt,
    output logic          done
);

    localparam logic [CW-1:0] NSH_C = CW'(NSH);

    logic [DW-1:0] shreg;
    logic [SW-1:0] lane_l;
    logic [SW-1:0] lane_r;
    logic [CW-1:0] cnt_inc;

`ifdef SHIFT_REG_UNIV_ROTATE_EN
    // Rotating feeds the lane that is falling off back into the opposite end.
    assign lane_l = rot ? shreg[DW-1 -: SW] : sin_l;
    assign lane_r = rot ? shreg[SW-1:0]     : sin_r;
`else
    assign lane_l = sin_l;
    assign lane_r = sin_r;
`endif

    assign cnt_inc = (cnt == NSH_C) ? cnt : cnt + CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else if (enb) begin
            case (mode)
                2'b01: begin
                    shreg <= {shreg[DW-SW-1:0], lane_l};
                    cnt   <= cnt_inc;
                    done  <= (cnt_inc == NSH_C);
                end
                2'b10: begin
                    shreg <= {lane_r, shreg[DW-1:SW]};
                    cnt   <= cnt_inc;
                    done  <= (cnt_inc == NSH_C);
                end
                2'b11: begin
                    shreg <= pin;
                    cnt   <= '0;
                    done  <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign pout   = shreg;
    assign sout_l = shreg[DW-1 -: SW];
    assign sout_r = shreg[SW-1:0];

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench for shift_reg_univ: directed scenarios plus randomized traffic against an arithmetic model.
module tb_shift_reg_univ;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    // instance A: DW=8, SW=1
    logic       a_enb;
    logic [1:0] a_mode;
    logic       a_sinl, a_sinr;
    logic [7:0] a_pin;
    logic       a_rot;
    logic [7:0] a_pout;
    logic       a_soutl, a_soutr;
    logic [3:0] a_cnt;
    logic       a_done;
    // instance B: DW=8, SW=2
    logic       b_enb;
    logic [1:0] b_mode;
    logic [1:0] b_sinl, b_sinr;
    logic [7:0] b_pin;
    logic [7:0] b_pout;
    logic [1:0] b_soutl, b_soutr;
    logic [2:0] b_cnt;
    logic       b_done;

    shift_reg_univ #(.DW(8), .SW(1)) dut_a (
        .clk(clk), .rst(rst), .enb(a_enb), .mode(a_mode),
        .sin_l(a_sinl), .sin_r(a_sinr), .pin(a_pin),
`ifdef SHIFT_REG_UNIV_ROTATE_EN
        .rot(a_rot),
`endif
        .pout(a_pout), .sout_l(a_soutl), .sout_r(a_soutr),
        .cnt(a_cnt), .done(a_done)
    );

    shift_reg_univ #(.DW(8), .SW(2)) dut_b (
        .clk(clk), .rst(rst), .enb(b_enb), .mode(b_mode),
        .sin_l(b_sinl), .sin_r(b_sinr), .pin(b_pin),
`ifdef SHIFT_REG_UNIV_ROTATE_EN
        .rot(1'b0),
`endif
        .pout(b_pout), .sout_l(b_soutl), .sout_r(b_soutr),
        .cnt(b_cnt), .done(b_done)
    );

    int checks = 0;
    int errors = 0;

    // Reference model of instance A as plain integers.
    int m_val  = 0;
    int m_cnt  = 0;
    int m_done = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_a(input string tag);
        chk({tag, ".pout"},   {24'd0, a_pout},   m_val);
        chk({tag, ".sout_l"}, {31'd0, a_soutl},  m_val / 128);
        chk({tag, ".sout_r"}, {31'd0, a_soutr},  m_val % 2);
        chk({tag, ".cnt"},    {28'd0, a_cnt},    m_cnt);
        chk({tag, ".done"},   {31'd0, a_done},   m_done);
    endtask

    // Drive one cycle of instance A, advance the model at the edge, check 1 time unit later.
    task automatic op_a(input logic e, input logic [1:0] m, input logic sl, input logic sr,
                        input logic [7:0] p, input string tag);
        int lane_l, lane_r;
        a_enb = e; a_mode = m; a_sinl = sl; a_sinr = sr; a_pin = p;
        lane_l = a_rot ? m_val / 128 : int'(sl);
        lane_r = a_rot ? m_val % 2   : int'(sr);
        @(posedge clk);
        if (e) begin
            if (m == 2'b01 || m == 2'b10) begin
                if (m == 2'b01) m_val = (m_val * 2) % 256 + lane_l;
                else            m_val = m_val / 2 + lane_r * 128;
                if (m_cnt < 8) m_cnt = m_cnt + 1;
                m_done = (m_cnt == 8) ? 1 : 0;
            end else if (m == 2'b11) begin
                m_val = int'(p); m_cnt = 0; m_done = 0;
            end
        end
        #1;
        check_a(tag);
    endtask

    task automatic tick_b();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] seq;

    initial begin
        rst = 1'b1; a_rot = 1'b0;
        a_enb = 0; a_mode = 0; a_sinl = 0; a_sinr = 0; a_pin = 0;
        b_enb = 0; b_mode = 0; b_sinl = 0; b_sinr = 0; b_pin = 0;
        repeat (2) @(posedge clk);
        #1;
        check_a("reset");
        chk("b_reset.pout", {24'd0, b_pout}, 0);
        rst = 1'b0;

        // Load A5, shift out MSB first with zero fill.
        op_a(1, 2'b11, 0, 0, 8'hA5, "load_a5");
        seq = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            chk("a5_sout_l_seq", {31'd0, a_soutl}, {31'd0, seq[7-i]});
            op_a(1, 2'b01, 0, 0, 8'h00, "a5_shl");
        end
        chk("a5_final_pout", {24'd0, a_pout}, 32'h00);
        chk("a5_final_done", {31'd0, a_done}, 1);

        // Load 81, shift right with 1, then hold.
        op_a(1, 2'b11, 0, 0, 8'h81, "load_81");
        op_a(1, 2'b10, 0, 1, 8'h00, "shr_81");
        chk("shr_81_c0", {24'd0, a_pout}, 32'hC0);
        for (int i = 0; i < 5; i++) op_a(1, 2'b00, 1, 1, 8'hFF, "hold_mode00");
        for (int i = 0; i < 3; i++) op_a(0, 2'b01, 1, 1, 8'hFF, "hold_enb0");

        // Saturation and reload.
        op_a(1, 2'b11, 0, 0, 8'hFF, "load_ff");
        for (int i = 0; i < 10; i++) op_a(1, 2'b01, 0, 0, 8'h00, "sat_shl");
        chk("sat_cnt", {28'd0, a_cnt}, 8);
        op_a(1, 2'b11, 0, 0, 8'h3C, "reload_3c");
        chk("reload_cnt", {28'd0, a_cnt}, 0);

        // Mixed direction counts every shift.
        for (int i = 0; i < 4; i++) op_a(1, 2'b01, 1, 0, 8'h00, "mix_l");
        for (int i = 0; i < 4; i++) op_a(1, 2'b10, 0, 1, 8'h00, "mix_r");
        chk("mix_done", {31'd0, a_done}, 1);

        // Asynchronous reset in the middle of a shift sequence.
        op_a(1, 2'b11, 0, 0, 8'h5A, "load_5a");
        for (int i = 0; i < 3; i++) op_a(1, 2'b01, 1, 0, 8'h00, "5a_shl");
        #3 rst = 1'b1;
        #1;
        m_val = 0; m_cnt = 0; m_done = 0;
        check_a("async_rst");
        #1 rst = 1'b0;
        op_a(0, 2'b11, 0, 0, 8'hFF, "post_rst_enb0_load");
        op_a(1, 2'b01, 1, 0, 8'h00, "post_rst_shl");
        chk("post_rst_first_cnt", {28'd0, a_cnt}, 1);

`ifdef SHIFT_REG_UNIV_ROTATE_EN
        a_rot = 1'b1;
        op_a(1, 2'b11, 0, 0, 8'h81, "rot_load");
        op_a(1, 2'b10, 0, 0, 8'h00, "rot_r");
        chk("rot_r_c0", {24'd0, a_pout}, 32'hC0);
        op_a(1, 2'b11, 0, 0, 8'h81, "rot_load2");
        for (int i = 0; i < 8; i++) op_a(1, 2'b01, 0, 0, 8'h00, "rot_l");
        chk("rot_l_81", {24'd0, a_pout}, 32'h81);
        a_rot = 1'b0;
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++)
            op_a(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 1'($urandom),
                 1'($urandom), 8'($urandom), "random");
        a_enb = 0;

        // Two-bit lanes.
        b_enb = 1; b_mode = 2'b11; b_pin = 8'hB4;
        tick_b();
        chk("b_load.pout", {24'd0, b_pout}, 32'hB4);
        b_mode = 2'b01; b_sinl = 2'b11;
        tick_b();
        chk("b_shl.pout",   {24'd0, b_pout},  32'hD3);
        chk("b_shl.sout_l", {30'd0, b_soutl}, 3);
        chk("b_shl.sout_r", {30'd0, b_soutr}, 3);
        chk("b_shl.cnt",    {29'd0, b_cnt},   1);
        chk("b_shl.done",   {31'd0, b_done},  0);
        b_sinl = 2'b00;
        repeat (2) tick_b();
        chk("b_3shl.done",  {31'd0, b_done},  0);
        tick_b();
        chk("b_4shl.cnt",   {29'd0, b_cnt},   4);
        chk("b_4shl.done",  {31'd0, b_done},  1);
        chk("b_4shl.pout",  {24'd0, b_pout},  32'hC0);
        b_mode = 2'b10; b_sinr = 2'b10;
        tick_b();
        chk("b_shr.pout",   {24'd0, b_pout},  32'hB0);
        chk("b_shr.cnt",    {29'd0, b_cnt},   4);
        b_enb = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
